// File: rtl/gf180mcu_ht_io_pwr_pkg.sv
// Shared types for the HT IO ring power-segment sequencer.
package gf180mcu_ht_io_pwr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ON_WAIT,
    ST_SETTLE,
    ST_UP,
    ST_OFF,
    ST_FAULT
  } state_t;

  // Width of a segment index; a single-segment ring still gets one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_ht_io__sync2.sv
// Two-flop synchroniser, W bits wide, resets to 0.
module gf180mcu_ht_io__sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gf180mcu_ht_io__pwr_seq.sv
// Ring power-segment sequencer: ascending power-up with PG wait and settle, descending ramp-down, sticky timeout fault.
// Define GF180MCU_HT_IO_PWR_SEQ_PGMON_EN to fault on loss of any power-good while the ring is up.
module gf180mcu_ht_io__pwr_seq
  import gf180mcu_ht_io_pwr_pkg::*;
#(
  parameter int NSEG      = 4,
  parameter int CNT_W     = 16,
  parameter int T_SETTLE  = 1000,
  parameter int T_TIMEOUT = 50000
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    REQ,
  input  logic [NSEG-1:0]         PG,
  output logic [NSEG-1:0]         EN,
  output logic [NSEG-1:0]         ISO_N,
  output logic                    READY,
  output logic                    FAULT,
  output logic [idx_w(NSEG)-1:0]  FAULT_SEG
);

  localparam int IW = idx_w(NSEG);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(T_TIMEOUT - 1);
  localparam logic [IW-1:0]    IDX_LAST     = IW'(NSEG - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [NSEG-1:0]   en_q, en_d;
  logic [NSEG-1:0]   iso_q, iso_d;
  logic              fault_q, fault_d;
  logic [IW-1:0]     fseg_q, fseg_d;
  logic [NSEG-1:0]   pgs;

  gf180mcu_ht_io__sync2 #(.W(NSEG)) u_pg_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (PG),
    .q     (pgs)
  );

  logic          pg_cur, timeout, settle_done, idx_is_last, idx_is_first, off_phase;
  logic [IW-1:0] idx_nx;

  assign pg_cur       = pgs[idx_q];
  assign timeout      = (timer_q == TIMEOUT_LAST);
  assign settle_done  = (timer_q == SETTLE_LAST);
  assign idx_is_last  = (idx_q == IDX_LAST);
  assign idx_is_first = (idx_q == '0);
  assign idx_nx       = idx_q + IW'(1);
  // Timer LSB splits each ramp-down step into isolate then disable.
  assign off_phase    = timer_q[0];

  logic          mon_fault;
  logic [IW-1:0] mon_idx;

`ifdef GF180MCU_HT_IO_PWR_SEQ_PGMON_EN
  always_comb begin
    mon_fault = 1'b0;
    mon_idx   = '0;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (!pgs[i]) begin
        mon_fault = 1'b1;
        mon_idx   = IW'(i);
      end
    end
  end
`else
  assign mon_fault = 1'b0;
  assign mon_idx   = '0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      en_q    <= '0;
      iso_q   <= '0;
      fault_q <= 1'b0;
      fseg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      en_q    <= en_d;
      iso_q   <= iso_d;
      fault_q <= fault_d;
      fseg_q  <= fseg_d;
    end
  end

  // Timeout outranks a coincident PG so late power-good still faults.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (REQ) state_d = ST_ON_WAIT;
      ST_ON_WAIT: begin
        if (!REQ)        state_d = ST_OFF;
        else if (timeout) state_d = ST_FAULT;
        else if (pg_cur)  state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!REQ)             state_d = ST_OFF;
        else if (settle_done) state_d = idx_is_last ? ST_UP : ST_ON_WAIT;
      end
      ST_UP: begin
        if (mon_fault) state_d = ST_FAULT;
        else if (!REQ) state_d = ST_OFF;
      end
      ST_OFF:     if (off_phase && idx_is_first) state_d = ST_IDLE;
      ST_FAULT:   if (!REQ) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    iso_d   = iso_q;
    idx_d   = idx_q;
    timer_d = timer_q + CNT_W'(1);
    fault_d = fault_q;
    fseg_d  = fseg_q;
    case (state_q)
      ST_IDLE: begin
        en_d    = '0;
        iso_d   = '0;
        idx_d   = '0;
        timer_d = '0;
        fault_d = 1'b0;
        fseg_d  = '0;
        if (REQ) en_d[0] = 1'b1;
      end
      ST_ON_WAIT: begin
        if (!REQ || (!timeout && pg_cur)) timer_d = '0;
      end
      ST_SETTLE: begin
        if (!REQ) begin
          timer_d = '0;
        end else if (settle_done) begin
          timer_d      = '0;
          iso_d[idx_q] = 1'b1;
          if (!idx_is_last) begin
            idx_d       = idx_nx;
            en_d[idx_nx] = 1'b1;
          end
        end
      end
      ST_UP: begin
        timer_d = '0;
        if (mon_fault) begin
          en_d  = '0;
          iso_d = '0;
          idx_d = mon_idx;
        end else if (!REQ) begin
          idx_d = IDX_LAST;
        end
      end
      ST_OFF: begin
        if (!off_phase) begin
          iso_d[idx_q] = 1'b0;
        end else begin
          en_d[idx_q] = 1'b0;
          timer_d     = '0;
          if (!idx_is_first) idx_d = idx_q - IW'(1);
        end
      end
      ST_FAULT: begin
        if (!REQ) begin
          en_d    = '0;
          iso_d   = '0;
          fault_d = 1'b0;
          fseg_d  = '0;
        end else if (!fault_q) begin
          fault_d = 1'b1;
          fseg_d  = idx_q;
        end else begin
          en_d  = '0;
          iso_d = '0;
        end
      end
      default: begin
        en_d  = '0;
        iso_d = '0;
      end
    endcase
  end

  assign EN        = en_q;
  assign ISO_N     = iso_q;
  assign READY     = (state_q == ST_UP);
  assign FAULT     = fault_q;
  assign FAULT_SEG = fseg_q;

endmodule

// File: tb/tb_gf180mcu_ht_io__pwr_seq.sv
// Directed bench: power-up, ramp-down, timeout fault, abort in settle, async reset, PG monitor.
module tb_gf180mcu_ht_io__pwr_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req;
  logic [3:0] pg;
  logic [3:0] en;
  logic [3:0] iso_n;
  logic       ready;
  logic       fault;
  logic [1:0] fault_seg;

  logic [3:0] pg_mask = 4'hF;
  logic [3:0] e1 = '0;
  logic [3:0] e2 = '0;
  logic [3:0] echo = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] rd_iso [8] = '{4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
  logic [3:0] rd_en  [8] = '{4'b1111, 4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};

  always #5 clk = ~clk;

  // Each segment's power-good follows its enable three cycles later.
  always @(posedge clk) begin
    e1   <= en;
    e2   <= e1;
    echo <= e2;
  end
  assign pg = echo & pg_mask;

  gf180mcu_ht_io__pwr_seq #(
    .NSEG      (4),
    .CNT_W     (16),
    .T_SETTLE  (4),
    .T_TIMEOUT (16)
  ) dut (
    .CLK       (clk),
    .RESETN    (resetn),
    .REQ       (req),
    .PG        (pg),
    .EN        (en),
    .ISO_N     (iso_n),
    .READY     (ready),
    .FAULT     (fault),
    .FAULT_SEG (fault_seg)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ring_up();
    req = 1'b1;
    tick(1);
    chk("up_en0_latency", en, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick(9);
      chk("up_iso_before", iso_n, 4'((1 << i) - 1));
      chk("up_en_hold", en, 4'((1 << (i + 1)) - 1));
      chk("up_ready_early", 4'(ready), 4'd0);
      tick(1);
      chk("up_iso_release", iso_n, 4'((1 << (i + 1)) - 1));
      chk("up_en_next", en, (i < 3) ? 4'((1 << (i + 2)) - 1) : 4'hF);
    end
    chk("up_ready", 4'(ready), 4'd1);
  endtask

  initial begin
    resetn = 1'b0;
    req    = 1'b0;
    tick(2);
    chk("rst_en", en, 4'd0);
    chk("rst_iso", iso_n, 4'd0);
    chk("rst_ready", 4'(ready), 4'd0);
    chk("rst_fault", 4'(fault), 4'd0);
    chk("rst_fault_seg", 4'(fault_seg), 4'd0);
    resetn = 1'b1;
    tick(3);
    chk("idle_en", en, 4'd0);

    // Full power-up then hold.
    ring_up();
    tick(5);
    chk("up_hold_ready", 4'(ready), 4'd1);
    chk("up_hold_fault", 4'(fault), 4'd0);

    // Ramp-down: isolate then disable, top segment first.
    req = 1'b0;
    tick(1);
    chk("rd_ready_low", 4'(ready), 4'd0);
    chk("rd_iso_first", iso_n, 4'hF);
    chk("rd_en_first", en, 4'hF);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("rd_iso", iso_n, rd_iso[k]);
      chk("rd_en", en, rd_en[k]);
    end
    tick(6);
    chk("rd_idle_en", en, 4'd0);

    // Timeout on segment 2.
    pg_mask = 4'b1011;
    req = 1'b1;
    tick(21);
    chk("to_en2_on", en, 4'b0111);
    tick(16);
    chk("to_fault_early", 4'(fault), 4'd0);
    tick(1);
    chk("to_fault", 4'(fault), 4'd1);
    chk("to_fault_seg", 4'(fault_seg), 4'd2);
    chk("to_en_pre_clear", en, 4'b0111);
    tick(1);
    chk("to_en_clear", en, 4'd0);
    chk("to_iso_clear", iso_n, 4'd0);
    chk("to_fault_sticky", 4'(fault), 4'd1);
    tick(3);
    chk("to_fault_hold", 4'(fault), 4'd1);
    req = 1'b0;
    tick(1);
    chk("to_fault_clear", 4'(fault), 4'd0);
    pg_mask = 4'hF;
    tick(6);
    chk("to_idle_en", en, 4'd0);

    // Abort while segment 1 settles.
    req = 1'b1;
    tick(18);
    chk("ab_en", en, 4'b0011);
    chk("ab_iso", iso_n, 4'b0001);
    req = 1'b0;
    tick(2);
    chk("ab_iso_hold", iso_n, 4'b0001);
    chk("ab_en_hold", en, 4'b0011);
    tick(1);
    chk("ab_en1_off", en, 4'b0001);
    chk("ab_iso1_never", iso_n, 4'b0001);
    tick(1);
    chk("ab_iso0_off", iso_n, 4'd0);
    tick(1);
    chk("ab_en0_off", en, 4'd0);
    tick(6);

    // Up again, then lose PG on segments 1 and 3 together.
    ring_up();
    pg_mask = 4'b0101;
    tick(6);
`ifdef GF180MCU_HT_IO_PWR_SEQ_PGMON_EN
    chk("mon_fault", 4'(fault), 4'd1);
    chk("mon_fault_seg", 4'(fault_seg), 4'd1);
    chk("mon_en_off", en, 4'd0);
`else
    chk("nomon_ready", 4'(ready), 4'd1);
    chk("nomon_fault", 4'(fault), 4'd0);
    chk("nomon_en", en, 4'hF);
`endif

    // Async reset between clock edges.
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_en", en, 4'd0);
    chk("arst_iso", iso_n, 4'd0);
    chk("arst_ready", 4'(ready), 4'd0);
    chk("arst_fault", 4'(fault), 4'd0);
    req = 1'b0;
    pg_mask = 4'hF;
    tick(2);
    resetn = 1'b1;
    tick(2);
    chk("post_rst_en", en, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
